// File: rtl/scope_capture_ctrl_if.sv
// Write port of the external ping-pong sample RAM, plus the bank the renderer reads.
// The capture sequencer is the master; the RAM/renderer side is the slave.
interface scope_capture_ctrl_if #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 10
);
   logic              wr_en;
   logic              wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_bank;

   modport master (output wr_en, wr_bank, wr_addr, wr_data, rd_bank);
   modport slave  (input  wr_en, wr_bank, wr_addr, wr_data, rd_bank);
endinterface

// File: rtl/scope_capture_ctrl.sv
// Trigger/capture sequencer: decimates the sample stream, arms on a rising level
// crossing and writes one screen-width record into the write half of a ping-pong RAM.
module scope_capture_ctrl #(
   parameter int DATA_W         = 12,
   parameter int DEPTH          = 640,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_FRAMES = 4
) (
   input  logic                     clk100,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] sample_in,
   input  logic                     sample_valid,
   input  logic                     frame_start,
   input  logic signed [DATA_W-1:0] trig_level,
   input  logic [7:0]               decim,
   scope_capture_ctrl_if.master     ram,
   output logic                     capture_done,
   output logic                     trig_timeout
);

   typedef enum logic [1:0] {
      ARM,
      WAIT_TRIG,
      CAPTURE,
      HOLD
   } state_t;

   state_t                   state;
   logic [7:0]               dec_cnt;
   logic [7:0]               decim_l;
   logic [7:0]               tmo_cnt;
   logic signed [DATA_W-1:0] trig_level_l;
   logic signed [DATA_W-1:0] prev;
   logic [ADDR_W-1:0]        idx;
   logic                     auto_flag;

   logic accept;
   logic crossing;
   logic timed_out;

   assign accept    = sample_valid && (dec_cnt == decim_l);
   assign crossing  = (prev < trig_level_l) && (sample_in >= trig_level_l);
   assign timed_out = (tmo_cnt == 8'(TIMEOUT_FRAMES));

   // Decimation counter runs in every state so the sample phase never depends on the FSM.
   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         dec_cnt <= '0;
      end else if (sample_valid) begin
         if (dec_cnt == decim_l) begin
            dec_cnt <= '0;
         end else begin
            dec_cnt <= dec_cnt + 8'd1;
         end
      end
   end

   // Settings follow the ports only while armed, so a record is taken with one setup.
   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         decim_l      <= '0;
         trig_level_l <= '0;
      end else if (state == ARM) begin
         decim_l      <= decim;
         trig_level_l <= trig_level;
      end
   end

   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         state        <= ARM;
         ram.wr_en    <= 1'b0;
         ram.wr_addr  <= '0;
         ram.wr_data  <= '0;
         ram.wr_bank  <= 1'b0;
         ram.rd_bank  <= 1'b1;
         capture_done <= 1'b0;
         trig_timeout <= 1'b0;
         prev         <= '0;
         tmo_cnt      <= '0;
         idx          <= '0;
         auto_flag    <= 1'b0;
      end else begin
         ram.wr_en <= 1'b0;
         case (state)
            ARM: begin
               if (accept) begin
                  prev    <= sample_in;
                  tmo_cnt <= '0;
                  state   <= WAIT_TRIG;
               end
            end

            WAIT_TRIG: begin
               // The trigger decision below sees the count from before this edge.
               if (frame_start && !timed_out) begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
               if (accept) begin
                  prev <= sample_in;
                  if (crossing || timed_out) begin
                     ram.wr_en   <= 1'b1;
                     ram.wr_addr <= '0;
                     ram.wr_data <= sample_in;
                     auto_flag   <= !crossing;
                     idx         <= ADDR_W'(1);
                     state       <= CAPTURE;
                  end
               end
            end

            CAPTURE: begin
               if (accept) begin
                  ram.wr_en   <= 1'b1;
                  ram.wr_addr <= idx;
                  ram.wr_data <= sample_in;
                  idx         <= idx + ADDR_W'(1);
                  if (idx == ADDR_W'(DEPTH - 1)) begin
                     capture_done <= 1'b1;
                     state        <= HOLD;
                  end
               end
            end

            HOLD: begin
               // Banks only swap in vertical blank so the renderer never shows a torn trace.
               if (frame_start) begin
                  ram.wr_bank  <= ~ram.wr_bank;
                  ram.rd_bank  <= ~ram.rd_bank;
                  trig_timeout <= auto_flag;
                  capture_done <= 1'b0;
                  state        <= ARM;
               end
            end

            default: state <= ARM;
         endcase
      end
   end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl: expected RAM writes are queued as
// stimulus is driven and popped by a monitor as the write strobe appears.
module tb_scope_capture_ctrl;

   localparam real PI = 3.14159265358979;

   logic               clk100;
   logic               reset;
   logic signed [11:0] sample_in;
   logic               sample_valid;
   logic               frame_start;
   logic signed [11:0] trig_level;
   logic [7:0]         decim;
   logic               capture_done;
   logic               trig_timeout;

   scope_capture_ctrl_if #(.DATA_W(12), .ADDR_W(10)) ram_if ();

   scope_capture_ctrl #(
      .DATA_W(12),
      .DEPTH(640),
      .ADDR_W(10),
      .TIMEOUT_FRAMES(4)
   ) dut (
      .clk100(clk100),
      .reset(reset),
      .sample_in(sample_in),
      .sample_valid(sample_valid),
      .frame_start(frame_start),
      .trig_level(trig_level),
      .decim(decim),
      .ram(ram_if),
      .capture_done(capture_done),
      .trig_timeout(trig_timeout)
   );

   typedef struct {
      int   addr;
      int   data;
      logic bank;
   } wr_t;

   wr_t exp_q[$];
   int  log_data[$];
   int  log_k[$];
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  test_writes = 0;
   int  first_wr_cyc = 0;
   int  last_wr_cyc = 0;
   int  cur_k = 0;
   bit  sb_mode = 1'b1;

   initial begin
      clk100 = 1'b0;
      forever #5 clk100 = ~clk100;
   end

   initial begin
      forever begin
         @(posedge clk100);
         cyc++;
      end
   end

   // Write monitor: scoreboard pop in sb_mode, raw logging otherwise.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk100);
         checks++;
         if (ram_if.rd_bank !== ~ram_if.wr_bank) begin
            failures++;
            $display("[TB] FAIL bank_invariant: rd_bank=%b wr_bank=%b expected rd_bank=~wr_bank",
                     ram_if.rd_bank, ram_if.wr_bank);
         end
         if (ram_if.wr_en === 1'b1) begin
            if (test_writes == 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            test_writes++;
            if (!sb_mode) begin
               log_data.push_back(int'($signed(ram_if.wr_data)));
               log_k.push_back(cur_k);
            end else if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_write: addr=%0d data=%0d bank=%b, expected no write",
                        ram_if.wr_addr, $signed(ram_if.wr_data), ram_if.wr_bank);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (ram_if.wr_addr !== 10'(e.addr) || ram_if.wr_data !== 12'(e.data) ||
                   ram_if.wr_bank !== e.bank) begin
                  failures++;
                  $display("[TB] FAIL write: got addr=%0d data=%0d bank=%b expected addr=%0d data=%0d bank=%b",
                           ram_if.wr_addr, $signed(ram_if.wr_data), ram_if.wr_bank,
                           e.addr, 12'(e.data), e.bank);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk100);
      #1;
   endtask

   task automatic push_exp(input int a, input int d, input logic b);
      wr_t e;
      e.addr = a;
      e.data = d;
      e.bank = b;
      exp_q.push_back(e);
   endtask

   task automatic run_ramp(input int first, input int last, input int fs_at);
      for (int v = first; v <= last; v++) begin
         sample_in    = 12'(v);
         sample_valid = 1'b1;
         frame_start  = (v == fs_at);
         step();
      end
      sample_valid = 1'b0;
      frame_start  = 1'b0;
      repeat (3) step();
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      checks++;
      if ({ram_if.wr_en, ram_if.wr_addr, ram_if.wr_data, ram_if.wr_bank, ram_if.rd_bank,
           capture_done, trig_timeout} !== {1'b0, 10'd0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL reset_values: got en=%b addr=%0d data=%0d wb=%b rb=%b done=%b tmo=%b expected 0/0/0/0/1/0/0",
                  ram_if.wr_en, ram_if.wr_addr, ram_if.wr_data, ram_if.wr_bank, ram_if.rd_bank,
                  capture_done, trig_timeout);
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_ramp();
      decim = 8'd0;
      trig_level = 12'sd0;
      step();
      test_writes = 0;
      for (int i = 0; i < 640; i++) push_exp(i, i, 1'b0);
      run_ramp(-100, 1000, -1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL ramp_pending: %0d writes missing, expected 0", exp_q.size());
      end
      exp_q.delete();
      checks++;
      if (test_writes != 640) begin
         failures++;
         $display("[TB] FAIL ramp_write_count: got %0d expected 640", test_writes);
      end
      checks++;
      if (capture_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL ramp_done: got %b expected 1", capture_done);
      end
   endtask

   task automatic test_swap();
      pulse_frame();
      checks++;
      if ({ram_if.wr_bank, ram_if.rd_bank, capture_done, trig_timeout} !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL swap1: got wb=%b rb=%b done=%b tmo=%b expected 1/0/0/0",
                  ram_if.wr_bank, ram_if.rd_bank, capture_done, trig_timeout);
      end
      test_writes = 0;
      for (int i = 0; i < 640; i++) push_exp(i, i, 1'b1);
      run_ramp(-100, 1000, 639);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL swap_pending: %0d writes missing, expected 0", exp_q.size());
      end
      exp_q.delete();
      checks++;
      if ({ram_if.wr_bank, capture_done} !== 2'b11) begin
         failures++;
         $display("[TB] FAIL coincident_no_swap: got wb=%b done=%b expected 1/1",
                  ram_if.wr_bank, capture_done);
      end
      pulse_frame();
      checks++;
      if ({ram_if.wr_bank, ram_if.rd_bank, capture_done} !== 3'b010) begin
         failures++;
         $display("[TB] FAIL swap2: got wb=%b rb=%b done=%b expected 0/1/0",
                  ram_if.wr_bank, ram_if.rd_bank, capture_done);
      end
   endtask

   task automatic test_decimation();
      decim = 8'd3;
      step();
      test_writes = 0;
      // Fourth valid sample after a zero phase is kept: -97, -93, ... -1, 3, 7, ...
      for (int i = 0; i < 640; i++) push_exp(i, 3 + 4 * i, 1'b0);
      run_ramp(-100, 2699, -1);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL decim_pending: %0d writes missing, expected 0", exp_q.size());
      end
      exp_q.delete();
      checks++;
      if (last_wr_cyc - first_wr_cyc != 2556) begin
         failures++;
         $display("[TB] FAIL decim_span: got %0d cycles expected 2556", last_wr_cyc - first_wr_cyc);
      end
      pulse_frame();
      checks++;
      if ({ram_if.wr_bank, trig_timeout, capture_done} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL decim_swap: got wb=%b tmo=%b done=%b expected 1/0/0",
                  ram_if.wr_bank, trig_timeout, capture_done);
      end
   endtask

   task automatic test_timeout();
      int fs_cyc;
      decim = 8'd0;
      trig_level = 12'sd100;
      sample_in = 12'sd50;
      step();
      test_writes = 0;
      fs_cyc = 0;
      sample_valid = 1'b1;
      repeat (5) step();
      for (int f = 1; f <= 4; f++) begin
         repeat (10) step();
         pulse_frame();
         fs_cyc = cyc;
      end
      checks++;
      if (test_writes != 0) begin
         failures++;
         $display("[TB] FAIL timeout_early: got %0d writes expected 0", test_writes);
      end
      for (int i = 0; i < 640; i++) push_exp(i, 50, 1'b1);
      repeat (650) step();
      sample_valid = 1'b0;
      step();
      checks++;
      if (first_wr_cyc != fs_cyc + 1) begin
         failures++;
         $display("[TB] FAIL timeout_first_cycle: got %0d expected %0d", first_wr_cyc, fs_cyc + 1);
      end
      checks++;
      if (exp_q.size() != 0 || capture_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL timeout_record: pending=%0d done=%b expected 0/1", exp_q.size(), capture_done);
      end
      exp_q.delete();
      pulse_frame();
      checks++;
      if ({trig_timeout, ram_if.wr_bank, ram_if.rd_bank} !== 3'b101) begin
         failures++;
         $display("[TB] FAIL timeout_flag: got tmo=%b wb=%b rb=%b expected 1/0/1",
                  trig_timeout, ram_if.wr_bank, ram_if.rd_bank);
      end
   endtask

   task automatic test_sine_and_abort();
      int bad;
      decim = 8'd255;
      trig_level = 12'sd0;
      step();
      sb_mode = 1'b0;
      log_data.delete();
      log_k.delete();
      for (int k = 49000; k < 120000; k++) begin
         sample_in    = 12'($rtoi(127.0 * $sin(2.0 * PI * real'(k) / 100000.0)));
         sample_valid = 1'b1;
         cur_k = k;
         step();
         if (log_data.size() >= 40) break;
      end
      // Asynchronous reset mid-record, sampled before any further clock edge.
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({ram_if.wr_en, ram_if.wr_addr, ram_if.wr_data, ram_if.wr_bank, ram_if.rd_bank,
           capture_done, trig_timeout} !== {1'b0, 10'd0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL async_reset: got en=%b addr=%0d data=%0d wb=%b rb=%b done=%b tmo=%b expected 0/0/0/0/1/0/0",
                  ram_if.wr_en, ram_if.wr_addr, ram_if.wr_data, ram_if.wr_bank, ram_if.rd_bank,
                  capture_done, trig_timeout);
      end
      sample_valid = 1'b0;
      sb_mode = 1'b1;
      checks++;
      if (log_data.size() < 38) begin
         failures++;
         $display("[TB] FAIL sine_count: got %0d writes expected at least 38", log_data.size());
      end else begin
         checks++;
         if (log_data[0] < 0 || log_data[0] > 1) begin
            failures++;
            $display("[TB] FAIL sine_first: got %0d expected 0..1", log_data[0]);
         end
         checks++;
         if (log_k[0] < 75000) begin
            failures++;
            $display("[TB] FAIL sine_falling_trigger: triggered near k=%0d expected after 75000", log_k[0]);
         end
         bad = 0;
         for (int i = 1; i < 38; i++) if (log_data[i] < log_data[i-1]) bad++;
         checks++;
         if (bad != 0) begin
            failures++;
            $display("[TB] FAIL sine_monotonic: got %0d decreasing steps expected 0", bad);
         end
      end
      decim = 8'd0;
      repeat (2) step();
      reset = 1'b0;
      step();
      test_writes = 0;
      sample_in = 12'sd100;
      sample_valid = 1'b1;
      repeat (30) step();
      checks++;
      if (test_writes != 0) begin
         failures++;
         $display("[TB] FAIL rearm_no_trigger: got %0d writes expected 0", test_writes);
      end
      for (int i = 0; i < 640; i++) push_exp(i, i, 1'b0);
      run_ramp(-5, 700, -1);
      checks++;
      if (exp_q.size() != 0 || capture_done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rearm_record: pending=%0d done=%b expected 0/1", exp_q.size(), capture_done);
      end
      exp_q.delete();
   endtask

   initial begin
      reset        = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      frame_start  = 1'b0;
      trig_level   = '0;
      decim        = '0;
      test_reset();
      test_ramp();
      test_swap();
      test_decimation();
      test_timeout();
      test_sine_and_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scope_capture_ctrl.md
Name: scope_capture_ctrl

Overview:
- Trigger and capture sequencer between the CORDIC sample stream and the VGA waveform renderer.
- Decimates incoming signed samples and arms on a rising level crossing.
- Writes one screen-width record into the write half of an external ping-pong sample RAM.
- Swaps RAM halves only at frame start, so the renderer never shows a torn trace.

Parameters:
DATA_W, 12, sample width (signed, two's complement)
DEPTH, 640, samples per capture record (one per horizontal pixel); must be >= 2 and <= 2**ADDR_W
ADDR_W, 10, RAM address width per bank
TIMEOUT_FRAMES, 4, frame_start pulses in WAIT_TRIG before free-run auto-trigger; range 1..255

Ports:
clk100  in  1  system clock
reset  in  1  asynchronous, active-high reset
sample_in  in  DATA_W  signed sample from the CORDIC datapath
sample_valid  in  1  sample_in valid this cycle (may be high every cycle)
frame_start  in  1  single-cycle pulse at start of VGA vertical blank
trig_level  in  DATA_W  signed trigger threshold
decim  in  8  keep 1 of every decim+1 valid samples
wr_en  out  1  RAM write strobe
wr_bank  out  1  bank being written
wr_addr  out  ADDR_W  RAM write address within wr_bank
wr_data  out  DATA_W  RAM write data
rd_bank  out  1  bank the renderer reads; always == ~wr_bank
capture_done  out  1  high while a complete record waits for swap
trig_timeout  out  1  last swapped record was auto-triggered

Behaviour:
- Reset values (async): state=ARM, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, rd_bank=1, capture_done=0, trig_timeout=0.
- Reset values of internal registers: dec_cnt=0, timeout counter=0, prev sample=0.
- Reset mid-capture aborts the capture; the partial record is never displayed.
- Decimation:
  - dec_cnt counts sample_valid cycles in every state.
  - A sample is accepted when sample_valid && dec_cnt==decim_l. dec_cnt then wraps to 0; otherwise it increments.
  - decim_l=0 accepts every valid sample.
- Configuration latching: decim_l and trig_level_l load from their ports every cycle in ARM and are held in all other states.
- ARM: on the first accepted sample, store it as prev, clear the timeout counter, go to WAIT_TRIG. No write.
- WAIT_TRIG:
  - Each accepted sample s is compared with prev. Trigger when prev < trig_level_l && s >= trig_level_l (signed compare). prev <= s on every accepted sample.
  - On trigger: write s at address 0, set auto flag=0, go to CAPTURE with next index 1.
  - Timeout: each frame_start increments the counter. When the counter reaches TIMEOUT_FRAMES, the next accepted sample is written at address 0 unconditionally, auto flag=1, go to CAPTURE.
  - If frame_start and an accepted sample coincide, the trigger check uses the pre-increment count.
- CAPTURE:
  - Each accepted sample is written at index 1..DEPTH-1 in order.
  - After writing index DEPTH-1, go to HOLD; capture_done=1 from the next cycle.
- Write timing (applies to WAIT_TRIG and CAPTURE):
  - Registered, 1-cycle latency. The accepting edge drives wr_en=1, wr_addr=index, wr_data=sample for exactly one cycle.
  - wr_en=0 in all other cycles.
  - wr_bank is stable throughout a capture.
- HOLD:
  - sample_valid is ignored for capture (dec_cnt still runs).
  - On frame_start: wr_bank toggles, rd_bank toggles, trig_timeout<=auto flag, capture_done=0, go to ARM.
  - A frame_start on the same edge as the DEPTH-1 write does not cause a swap; the swap waits for the next frame_start.
- frame_start in ARM or CAPTURE is ignored.
- Invariant: rd_bank == ~wr_bank at all times.
- wr_addr never exceeds DEPTH-1.

Test Plan:
- Reset: assert reset asynchronously mid-CAPTURE -> outputs go to reset values immediately (no clock needed), wr_bank=0, rd_bank=1; after release, first write waits for a new trigger.
- Ramp trigger: trig_level=0, decim=0, sample_valid=1, sample_in ramps -100..+1000 by 1 per cycle -> first wr_en has wr_addr=0, wr_data=0; record holds 0..639 at addresses 0..639; capture_done=1; no further writes.
- Swap: after the ramp capture, pulse frame_start -> next cycle wr_bank=1, rd_bank=0, capture_done=0, trig_timeout=0. Repeat the capture: frame_start coincident with the final write -> no swap; the next frame_start swaps.
- Decimation: decim=3 with the same ramp -> consecutive writes are 4 cycles apart with data stepping by 4; total record time 2560 accepted-source cycles.
- Timeout: sample_in constant 50, trig_level=100, TIMEOUT_FRAMES=4 -> no write before the 4th frame_start; the next sample is written at address 0; after the swap trig_timeout=1.
- Sine: 127*sin(2*pi*1 kHz*t) sampled at 100 MHz, decim=255, trig_level=0 -> wr_data at address 0 is in 0..1; record is monotonic rising for the first ~38 entries; no negative-going trigger.
